telem_decoder: RTL and testbench
================================

Name: telem_decoder

Overview:
- Consumes the byte stream produced by UART_rcv on the eBike TX telemetry line.
- Hunts for the 0xAA,0x55 frame delimiter and reassembles the six payload bytes into 12-bit BATT, CURR and TORQUE words.
- Presents the words atomically with a one-cycle valid strobe, plus framing-error and packet statistics.
- Sits directly downstream of UART_rcv in eBike_tb; also usable as a host-side telemetry monitor.

Parameters:
- TIMEOUT_CYC, 65536, maximum idle clocks between bytes inside a frame before the frame is aborted (>2 byte times at 19200 baud / 50 MHz).
- DELIM1, 8'hAA, first delimiter byte.
- DELIM2, 8'h55, second delimiter byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  received byte from UART_rcv
- rdy  in  1  byte-ready flag from UART_rcv
- clr_rdy  out  1  acknowledge to UART_rcv
- batt  out  12  last complete BATT value
- curr  out  12  last complete CURR value
- torque  out  12  last complete TORQUE value
- vld  out  1  one-cycle pulse when batt/curr/torque update
- frame_err  out  1  one-cycle pulse on malformed or timed-out frame
- pkt_cnt  out  8  good frames received, wraps 255->0
- err_cnt  out  8  frame errors, saturates at 255

Behaviour:
- Reset (async, rst_n=0): state HUNT1, all outputs 0, shadow registers 0, idle counter 0.
- Byte accept:
  - clr_rdy = rdy (combinational).
  - A byte is accepted only on a rdy rising edge (rdy=1, rdy_q=0); rdy held high never re-accepts the same byte.
- Frame format, 8 bytes: AA, 55, {4'h0,batt[11:8]}, batt[7:0], {4'h0,curr[11:8]}, curr[7:0], {4'h0,torque[11:8]}, torque[7:0].
- States:
  - HUNT1: accepted byte == DELIM1 -> HUNT2; otherwise stay. No error reported.
  - HUNT2: byte == DELIM2 -> PAYLOAD with idx=0. byte == DELIM1 -> stay in HUNT2. Other bytes -> HUNT1 with frame_err.
  - PAYLOAD: idx 0..5.
    - Even idx (high bytes): byte[7:4] must be 0, else frame_err. After the error, byte == DELIM1 -> HUNT2, otherwise -> HUNT1.
    - Valid bytes are written into shadow registers; idx increments.
    - After idx=5 accepted -> HUNT1.
- Output update:
  - On the clock edge after the idx=5 byte is accepted, batt/curr/torque load from the shadows simultaneously.
  - vld=1 for exactly that cycle; pkt_cnt increments on the same edge.
  - Latency: 1 clock from accept of the last byte.
- Outputs hold their last good values through partial, erroneous and aborted frames; they never show a mix of two frames.
- Timeout:
  - Idle counter clears on every accepted byte and counts only in HUNT2/PAYLOAD.
  - Reaching TIMEOUT_CYC-1 -> HUNT1 with frame_err; the counter clears.
  - The counter is held at 0 in HUNT1.
- frame_err:
  - One-cycle pulse, registered, asserted the cycle after the offending accept or timeout.
  - err_cnt increments on the same edge, saturating at 255.
- Simultaneous byte accept and timeout in the same cycle: the byte wins and the counter clears.
- vld and frame_err are never high together.

Decomposition:
- Package telem_pkg:
  - Enum state_t {HUNT1, HUNT2, PAYLOAD}.
  - Constants DELIM1/DELIM2 defaults and FRAME_PAYLOAD_BYTES=6.
  - localparam function for idle-counter width, $clog2(TIMEOUT_CYC).
- One natural sub-module, telem_timeout: the idle counter with clear/enable inputs and an expire output.
- FSM, shadows and statistics live in the top.

Test Plan:
1. Reset-release, then frame AA 55 0B 80 01 23 07 00 -> one vld pulse; batt=12'hB80, curr=12'h123, torque=12'h700; pkt_cnt=1; frame_err never asserted.
2. Garbage 13 AA AA 55 then payload 0F FF 00 00 05 00 -> leading 13 and extra AA silently skipped; batt=FFF, curr=000, torque=500; err_cnt=0.
3. AA 55 0B 80 3C … (bad high nibble at idx 2) -> frame_err pulse, err_cnt=1, no vld, outputs unchanged; following full good frame decodes correctly.
4. AA 55 0B then stall TIMEOUT_CYC clocks -> frame_err exactly once, return to HUNT1; next good frame yields vld.
5. 256 back-to-back good frames via UART_tx->UART_rcv loopback -> pkt_cnt wraps to 0, each frame one vld; 300 bad frames -> err_cnt saturates at 255.
6. Assert rst_n=0 mid-payload (after byte 5) -> outputs, counters and state zero asynchronously; post-reset the tail bytes are ignored until a new AA 55.

Source files
------------

// File: rtl/telem_pkg.sv
// Shared types and constants for the eBike telemetry frame decoder.
// Provides the FSM state type, delimiter defaults and idle-counter sizing.
package telem_pkg;

  typedef enum logic [1:0] {
    HUNT1,
    HUNT2,
    PAYLOAD
  } state_t;

  localparam logic [7:0] DELIM1_DEF = 8'hAA;
  localparam logic [7:0] DELIM2_DEF = 8'h55;
  localparam int FRAME_PAYLOAD_BYTES = 6;
  localparam int TIMEOUT_CYC_DEF = 65536;

  function automatic int idle_cnt_w(input int t);
    return (t < 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/telem_timeout.sv
// Inter-byte idle counter for frames in progress.
// Ports: clk, rst_n, clr (byte seen / hunting), en (frame open), expire.
module telem_timeout
  import telem_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = idle_cnt_w(TIMEOUT_CYC);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // A clear in the same cycle suppresses expiry: a late byte still counts.
  always_comb begin
    expire = en & ~clr & (cnt_q == LAST);
    cnt_d  = cnt_q + 1'b1;
    if (clr | ~en | expire) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/telem_decoder.sv
// Telemetry frame decoder: AA 55 + six payload bytes -> batt/curr/torque.
// Ports: rx_data/rdy in, clr_rdy ack, words + vld, frame_err, pkt/err counts.
module telem_decoder
  import telem_pkg::*;
#(
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [7:0] DELIM1      = DELIM1_DEF,
  parameter logic [7:0] DELIM2      = DELIM2_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rdy,
  output logic        clr_rdy,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] torque,
  output logic        vld,
  output logic        frame_err,
  output logic [7:0]  pkt_cnt,
  output logic [7:0]  err_cnt
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_PAYLOAD_BYTES - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        rdy_q;
  logic [11:0] sh_batt_q, sh_batt_d;
  logic [11:0] sh_curr_q, sh_curr_d;
  logic [11:0] sh_torque_q, sh_torque_d;
  logic [11:0] batt_q, batt_d;
  logic [11:0] curr_q, curr_d;
  logic [11:0] torque_q, torque_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;
  logic [7:0]  pkt_q, pkt_d;
  logic [7:0]  errc_q, errc_d;

  logic accept;
  logic expire;
  logic bad;
  logic done;

  assign clr_rdy = rdy;
  assign accept  = rdy & ~rdy_q;

  telem_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept | (state_q == HUNT1)),
    .en    (state_q != HUNT1),
    .expire(expire)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sh_batt_d   = sh_batt_q;
    sh_curr_d   = sh_curr_q;
    sh_torque_d = sh_torque_q;
    batt_d      = batt_q;
    curr_d      = curr_q;
    torque_d    = torque_q;
    pkt_d       = pkt_q;
    errc_d      = errc_q;
    vld_d       = 1'b0;
    err_d       = 1'b0;
    bad         = 1'b0;
    done        = 1'b0;
    if (accept) begin
      unique case (state_q)
        HUNT1: begin
          if (rx_data == DELIM1) state_d = HUNT2;
        end
        HUNT2: begin
          if (rx_data == DELIM2) begin
            state_d = PAYLOAD;
            idx_d   = '0;
          end else if (rx_data != DELIM1) begin
            state_d = HUNT1;
            bad     = 1'b1;
          end
        end
        PAYLOAD: begin
          if (!idx_q[0] && rx_data[7:4] != 4'h0) begin
            bad     = 1'b1;
            // A stray delimiter may be the start of the next frame.
            state_d = (rx_data == DELIM1) ? HUNT2 : HUNT1;
          end else begin
            unique case (idx_q)
              3'd0:    sh_batt_d[11:8]   = rx_data[3:0];
              3'd1:    sh_batt_d[7:0]    = rx_data;
              3'd2:    sh_curr_d[11:8]   = rx_data[3:0];
              3'd3:    sh_curr_d[7:0]    = rx_data;
              3'd4:    sh_torque_d[11:8] = rx_data[3:0];
              default: sh_torque_d[7:0]  = rx_data;
            endcase
            idx_d = idx_q + 3'd1;
            if (idx_q == LAST_IDX) begin
              done    = 1'b1;
              state_d = HUNT1;
            end
          end
        end
        default: state_d = HUNT1;
      endcase
    end else if (expire) begin
      bad     = 1'b1;
      state_d = HUNT1;
    end
    // Final byte bypasses its shadow so all three words move together.
    if (done) begin
      batt_d   = sh_batt_q;
      curr_d   = sh_curr_q;
      torque_d = {sh_torque_q[11:8], rx_data};
      vld_d    = 1'b1;
      pkt_d    = pkt_q + 8'd1;
    end
    if (bad) begin
      err_d = 1'b1;
      if (errc_q != 8'hFF) errc_d = errc_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT1;
      idx_q       <= '0;
      rdy_q       <= 1'b0;
      sh_batt_q   <= '0;
      sh_curr_q   <= '0;
      sh_torque_q <= '0;
      batt_q      <= '0;
      curr_q      <= '0;
      torque_q    <= '0;
      vld_q       <= 1'b0;
      err_q       <= 1'b0;
      pkt_q       <= '0;
      errc_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rdy_q       <= rdy;
      sh_batt_q   <= sh_batt_d;
      sh_curr_q   <= sh_curr_d;
      sh_torque_q <= sh_torque_d;
      batt_q      <= batt_d;
      curr_q      <= curr_d;
      torque_q    <= torque_d;
      vld_q       <= vld_d;
      err_q       <= err_d;
      pkt_q       <= pkt_d;
      errc_q      <= errc_d;
    end
  end

  assign batt      = batt_q;
  assign curr      = curr_q;
  assign torque    = torque_q;
  assign vld       = vld_q;
  assign frame_err = err_q;
  assign pkt_cnt   = pkt_q;
  assign err_cnt   = errc_q;

endmodule

// File: tb/tb_telem_decoder.sv
// Directed bench for telem_decoder with an event scoreboard.
// Expected vld/frame_err events are queued as bytes are driven.
module tb_telem_decoder;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rdy;
  logic [11:0] batt, curr, torque;
  logic        vld, frame_err;
  logic [7:0]  pkt_cnt, err_cnt;

  always #5 clk = ~clk;

  telem_decoder #(.TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rdy      (rdy),
    .clr_rdy  (clr_rdy),
    .batt     (batt),
    .curr     (curr),
    .torque   (torque),
    .vld      (vld),
    .frame_err(frame_err),
    .pkt_cnt  (pkt_cnt),
    .err_cnt  (err_cnt)
  );

  typedef struct {
    bit          is_vld;
    logic [11:0] b, c, t;
    logic [7:0]  p, e;
  } ev_t;

  ev_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [11:0] eb = '0, ec = '0, et = '0;
  logic [7:0]  ep = '0, ee = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    ev_t e;
    if (rst_n && (vld || frame_err)) begin
      chk("vld_err_excl", {31'b0, vld & frame_err}, 32'd0);
      chk("event_expected", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ev_kind_vld", {31'b0, vld}, {31'b0, e.is_vld});
        chk("ev_batt", {20'b0, batt}, {20'b0, e.b});
        chk("ev_curr", {20'b0, curr}, {20'b0, e.c});
        chk("ev_torque", {20'b0, torque}, {20'b0, e.t});
        chk("ev_pkt_cnt", {24'b0, pkt_cnt}, {24'b0, e.p});
        chk("ev_err_cnt", {24'b0, err_cnt}, {24'b0, e.e});
      end
    end
  end

  task automatic push(input bit is_vld);
    ev_t e;
    e.is_vld = is_vld;
    e.b = eb; e.c = ec; e.t = et; e.p = ep; e.e = ee;
    sb.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold = 1,
                           input int gap = 1);
    rx_data = b;
    rdy = 1'b1;
    repeat (hold) @(negedge clk);
    rdy = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic expect_err();
    ee = (ee == 8'hFF) ? 8'hFF : ee + 8'd1;
    push(1'b0);
  endtask

  task automatic payload(input logic [11:0] b, input logic [11:0] c,
                         input logic [11:0] t, input int hold = 1,
                         input int gap = 1);
    send_byte({4'h0, b[11:8]}, hold, gap);
    send_byte(b[7:0], hold, gap);
    send_byte({4'h0, c[11:8]}, hold, gap);
    send_byte(c[7:0], hold, gap);
    send_byte({4'h0, t[11:8]}, hold, gap);
    eb = b; ec = c; et = t; ep = ep + 8'd1;
    push(1'b1);
    send_byte(t[7:0], hold, gap);
  endtask

  task automatic good_frame(input logic [11:0] b, input logic [11:0] c,
                            input logic [11:0] t, input int hold = 1,
                            input int gap = 1);
    send_byte(8'hAA, hold, gap);
    send_byte(8'h55, hold, gap);
    payload(b, c, t, hold, gap);
  endtask

  task automatic drain(input string tag);
    repeat (4) @(negedge clk);
    chk(tag, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_batt", {20'b0, batt}, 32'd0);
    chk("rst_curr", {20'b0, curr}, 32'd0);
    chk("rst_torque", {20'b0, torque}, 32'd0);
    chk("rst_vld_err", {30'b0, vld, frame_err}, 32'd0);
    chk("rst_counts", {16'b0, pkt_cnt, err_cnt}, 32'd0);
    rdy = 1'b1;
    #1 chk("clr_rdy_hi", {31'b0, clr_rdy}, 32'd1);
    rdy = 1'b0;
    #1 chk("clr_rdy_lo", {31'b0, clr_rdy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame; rdy held high for several cycles per byte.
    good_frame(12'hB80, 12'h123, 12'h700, 3);
    drain("t1_drain");
    chk("t1_batt", {20'b0, batt}, 32'hB80);
    chk("t1_pkt", {24'b0, pkt_cnt}, 32'd1);

    // Leading garbage and a repeated first delimiter.
    send_byte(8'h13);
    send_byte(8'hAA);
    good_frame(12'hFFF, 12'h000, 12'h500);
    drain("t2_drain");
    chk("t2_torque", {20'b0, torque}, 32'h500);
    chk("t2_err_cnt", {24'b0, err_cnt}, 32'd0);

    // Bad high nibble, then recovery.
    send_byte(8'hAA); send_byte(8'h55);
    send_byte(8'h0B); send_byte(8'h80);
    expect_err();
    send_byte(8'h3C);
    good_frame(12'h0A5, 12'h5A0, 12'hFFF);
    // Non-delimiter in HUNT2.
    send_byte(8'hAA);
    expect_err();
    send_byte(8'h13);
    // Delimiter at a high-byte slot restarts a frame.
    send_byte(8'hAA); send_byte(8'h55);
    send_byte(8'h01); send_byte(8'h02);
    expect_err();
    send_byte(8'hAA);
    send_byte(8'h55);
    payload(12'h001, 12'h002, 12'h003);
    drain("t3_drain");
    chk("t3_err_cnt", {24'b0, err_cnt}, 32'd3);
    chk("t3_curr", {20'b0, curr}, 32'h002);

    // Idle timeout inside a frame.
    send_byte(8'hAA); send_byte(8'h55);
    expect_err();
    send_byte(8'h0B);
    repeat (TO + 10) @(negedge clk);
    chk("t4_timeout", 32'(sb.size()), 32'd0);
    chk("t4_batt_held", {20'b0, batt}, 32'h001);
    good_frame(12'h123, 12'h456, 12'h789);
    // Slow but within the idle limit.
    good_frame(12'h321, 12'h654, 12'h987, 1, 50);
    drain("t4_drain");

    // Counter wrap and saturation.
    for (int i = 0; i < 256; i++)
      good_frame(12'(i * 37), 12'(4095 - i), 12'(i << 4));
    drain("t5_pkt_drain");
    chk("t5_pkt_wrap", {24'b0, pkt_cnt}, 32'd6);
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hAA); send_byte(8'h55);
      expect_err();
      send_byte(8'hF0);
    end
    drain("t5_err_drain");
    chk("t5_err_sat", {24'b0, err_cnt}, 32'd255);

    // Asynchronous reset mid-payload.
    send_byte(8'hAA); send_byte(8'h55);
    send_byte(8'h0B); send_byte(8'h80); send_byte(8'h01);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_batt", {20'b0, batt}, 32'd0);
    chk("t6_torque", {20'b0, torque}, 32'd0);
    chk("t6_counts", {16'b0, pkt_cnt, err_cnt}, 32'd0);
    chk("t6_pulses", {30'b0, vld, frame_err}, 32'd0);
    eb = '0; ec = '0; et = '0; ep = '0; ee = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h23); send_byte(8'h07); send_byte(8'h00);
    repeat (TO + 10) @(negedge clk);
    chk("t6_tail_ignored", {20'b0, pkt_cnt, 4'h0}, 32'd0);
    chk("t6_no_err", {24'b0, err_cnt}, 32'd0);
    good_frame(12'hB80, 12'h123, 12'h700);
    drain("t6_drain");
    chk("t6_pkt", {24'b0, pkt_cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
